rr_arbiter8: RTL and testbench

Eight-requester round-robin arbiter that shares one downstream resource between requesters, using the team's 8-to-3 priority-encoding convention (highest index wins) with a rotating priority pointer for fairness. It sits between requesting agents and the shared resource. It issues a registered one-hot grant plus the encoded index and valid flag, and holds the grant until the owner releases it.

---
 rtl/arb_pkg.sv | 11 +
 rtl/rr_arbiter8_if.sv | 13 +
 rtl/rr_pick.sv | 28 ++
 rtl/rr_arbiter8.sv | 96 +++++++++
 tb/tb_rr_arbiter8.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared constants and types for the eight-requester round-robin arbiter.
// ARB_HOLD_LIMIT_EN (optional) makes MAX_HOLD the per-owner hold limit.
package arb_pkg;
  localparam int N        = 8;
  localparam int IDX_W    = 3;
  localparam int MAX_HOLD = 16;

  typedef enum logic {IDLE, OWNED} state_t;

  localparam logic [IDX_W-1:0] PTR_RST = 3'd7;
endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesting agents (master) and the arbiter (slave).
// Grant side is registered inside the arbiter; there is no backpressure, only hold/release.
interface rr_arbiter8_if;
  import arb_pkg::*;

  logic [N-1:0]     req;
  logic [N-1:0]     grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;

  modport master (output req, input grant, grant_idx, grant_valid);
  modport slave  (input req, output grant, grant_idx, grant_valid);
endinterface

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder: first set bit searching ptr, ptr-1, ... wrapping.
// Zero latency; found is low and pick/idx are zero when no bit is set.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic [IDX_W-1:0] idx,
  output logic             found
);
  logic [IDX_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = ptr - IDX_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    pick = '0;
    if (found) pick[idx] = 1'b1;
  end
endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter, 8 requesters: registered grant one cycle after req, held until release.
// No preemption; handoff on release is same-cycle. ARB_HOLD_LIMIT_EN adds a MAX_HOLD hold limit.
module rr_arbiter8
  import arb_pkg::*;
(
  input logic         clk,
  input logic         rst,
  rr_arbiter8_if.slave bus
);
  state_t           state;
  logic [N-1:0]     grant_q;
  logic [IDX_W-1:0] idx_q;
  logic             valid_q;
  logic [IDX_W-1:0] ptr;

  logic [N-1:0]     pick_req;
  logic [N-1:0]     pick;
  logic [IDX_W-1:0] pick_idx;
  logic             found;
  logic             release_now;

  // grant_q is zero in IDLE, so this masks the owner only while OWNED.
  assign pick_req = bus.req & ~grant_q;

  rr_pick u_pick (
    .req   (pick_req),
    .ptr   (ptr),
    .pick  (pick),
    .idx   (pick_idx),
    .found (found)
  );

`ifdef ARB_HOLD_LIMIT_EN
  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_expired;

  // Forced release only when someone else is waiting; otherwise the owner keeps it.
  assign hold_expired = (state == OWNED) && (hold_cnt == HOLD_LAST) && (|pick_req);
  assign release_now  = !bus.req[idx_q] || hold_expired;
`else
  assign release_now  = !bus.req[idx_q];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      ptr     <= PTR_RST;
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            grant_q <= pick;
            idx_q   <= pick_idx;
            valid_q <= 1'b1;
            ptr     <= pick_idx - IDX_W'(1);
            state   <= OWNED;
          end
        end
        OWNED: begin
          if (release_now) begin
            if (found) begin
              grant_q <= pick;
              idx_q   <= pick_idx;
              ptr     <= pick_idx - IDX_W'(1);
            end else begin
              grant_q <= '0;
              idx_q   <= '0;
              valid_q <= 1'b0;
              state   <= IDLE;
            end
          end
        end
      endcase
`ifdef ARB_HOLD_LIMIT_EN
      if (state != OWNED || release_now) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_LAST) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
`endif
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = valid_q;
endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed cases with literal expectations plus randomized traffic
// compared every cycle against a behavioural owner/pointer model.
module tb_rr_arbiter8;
  import arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  int m_owner = -1;
  int m_ptr   = 7;
  int m_cnt   = 0;

  rr_arbiter8_if bus ();

  rr_arbiter8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int search(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      int c;
      c = (p - k + 8) % 8;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  // Model of what the registers must hold after an edge that saw (r, rs).
  task automatic model_update(input logic [7:0] r, input logic rs);
    int  w;
    bit  rel;
    logic [7:0] others;
    if (rs) begin
      m_owner = -1; m_ptr = 7; m_cnt = 0;
    end else if (m_owner < 0) begin
      w = search(r, m_ptr);
      if (w >= 0) begin
        m_owner = w; m_ptr = (w + 7) % 8; m_cnt = 0;
      end
    end else begin
      others = r;
      others[m_owner] = 1'b0;
      rel = !r[m_owner];
`ifdef ARB_HOLD_LIMIT_EN
      if (m_cnt == MAX_HOLD - 1 && others != 8'h00) rel = 1'b1;
`endif
      if (rel) begin
        w = search(others, m_ptr);
        m_cnt = 0;
        if (w >= 0) begin
          m_owner = w; m_ptr = (w + 7) % 8;
        end else begin
          m_owner = -1;
        end
      end else if (m_cnt < MAX_HOLD - 1) begin
        m_cnt++;
      end
    end
  endtask

  task automatic step(input logic [7:0] r, input logic rs);
    bus.req = r;
    rst     = rs;
    @(posedge clk);
    #1;
    model_update(r, rs);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [7:0] eg;
      eg = '0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      chk("grant", int'(bus.grant), int'(eg));
      chk("grant_idx", int'(bus.grant_idx), (m_owner < 0) ? 0 : m_owner);
      chk("grant_valid", int'(bus.grant_valid), (m_owner >= 0) ? 1 : 0);
      chk("onehot0", int'($onehot0(bus.grant)), 1);
    end
  end

  initial begin
    logic [7:0] r;
    bus.req = '0;
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    cmp_en = 1'b1;
    chk("reset_grant", int'(bus.grant), 0);

    // MSB-first after reset, then release hands to bit 0
    step(8'b1000_0001, 1'b0);
    chk("first_grant", int'(bus.grant), 8'h80);
    chk("first_idx", int'(bus.grant_idx), 7);
    step(8'b0000_0001, 1'b0);
    chk("handoff_grant", int'(bus.grant), 8'h01);
    chk("handoff_idx", int'(bus.grant_idx), 0);

    // Full rotation, each owner holding two cycles
    step(8'h00, 1'b1);
    step(8'hFF, 1'b0);
    for (int k = 0; k < 9; k++) begin
      int o;
      o = (7 - k + 8) % 8;
      chk("rot_idx", int'(bus.grant_idx), o);
      step(8'hFF, 1'b0);
      r = 8'hFF;
      r[o] = 1'b0;
      step(r, 1'b0);
    end

    // Owner 4 never releases
    step(8'h00, 1'b1);
    step(8'b0001_0111, 1'b0);
    chk("hold_first", int'(bus.grant), 8'h10);
    for (int i = 0; i < 15; i++) step(8'b0001_0111, 1'b0);
    chk("hold_15", int'(bus.grant_idx), 4);
    step(8'b0001_0111, 1'b0);
`ifdef ARB_HOLD_LIMIT_EN
    chk("hold_16", int'(bus.grant_idx), 2);
`else
    chk("hold_16", int'(bus.grant_idx), 4);
`endif
    for (int i = 0; i < 10; i++) step(8'b0001_0111, 1'b0);

    // Idle with no requests, then a single requester
    step(8'h00, 1'b1);
    for (int i = 0; i < 5; i++) step(8'h00, 1'b0);
    chk("idle_valid", int'(bus.grant_valid), 0);
    chk("idle_idx", int'(bus.grant_idx), 0);
    step(8'b0000_0010, 1'b0);
    chk("single_idx", int'(bus.grant_idx), 1);

    // Reset mid-grant
    step(8'h00, 1'b1);
    step(8'b0010_0000, 1'b0);
    chk("pre_rst_idx", int'(bus.grant_idx), 5);
    step(8'b0010_0100, 1'b1);
    chk("rst_mid_grant", int'(bus.grant), 0);
    chk("rst_mid_valid", int'(bus.grant_valid), 0);
    step(8'b0010_0100, 1'b0);
    chk("post_rst_idx", int'(bus.grant_idx), 5);

    // Wrap-around: 1 -> 0 (ptr=0), then release 0 with req 10000010 -> 7
    step(8'h00, 1'b1);
    step(8'b0000_0010, 1'b0);
    step(8'b0000_0001, 1'b0);
    chk("wrap_owner0", int'(bus.grant_idx), 0);
    step(8'b1000_0010, 1'b0);
    chk("wrap_idx7", int'(bus.grant_idx), 7);
    step(8'b0000_0010, 1'b0);
    chk("wrap_ptr6", int'(bus.grant_idx), 1);

    // Random traffic with occasional reset
    r = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) r = 8'($urandom);
      step(r, ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
